toggle_monitor: RTL and testbench

Downstream consumer of the T flip-flop output `q`. It synchronises the toggling signal into the monitor clock domain and detects each transition. Over a programmable window it counts total transitions and rising transitions, then reports the result with a one-cycle `done` pulse. It is used to check that the toggle stage actually toggles at the expected rate for a given enable/data pattern.

---
 rtl/toggle_monitor_pkg.sv | 17 +
 rtl/sync_edge_det.sv | 39 +++
 rtl/toggle_monitor.sv | 131 +++++++++++++
 tb/tb_toggle_monitor.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_monitor_pkg.sv
// toggle_monitor_pkg
// Shared types and default widths for the toggle monitor.
//   tm_state_e : window FSM states (idle, counting, reporting)
//   TM_CNT_W   : default edge-counter width
//   TM_WIN_W   : default window-length / timer width
package toggle_monitor_pkg;

    localparam int unsigned TM_CNT_W = 8;
    localparam int unsigned TM_WIN_W = 8;

    typedef enum logic [1:0] {
        TM_IDLE  = 2'd0,
        TM_COUNT = 2'd1,
        TM_DONE  = 2'd2
    } tm_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det
// Brings an asynchronous level into the clk domain and flags its transitions.
//   clk        : sampling clock
//   rst_n      : asynchronous active-low reset, all flops cleared to 0
//   d          : asynchronous input level
//   level      : synchronised level (second synchroniser flop)
//   edge_pulse : one-cycle pulse per transition of the synchronised level
//   rise       : one-cycle pulse per 0->1 transition of the synchronised level
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic edge_pulse,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // s1/s2 form the metastability chain; s3 is history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level      = s2;
    assign edge_pulse = s2 ^ s3;
    assign rise       = s2 & ~s3;

endmodule

// File: rtl/toggle_monitor.sv
// toggle_monitor
// Counts transitions of an asynchronous toggle signal over a programmable window.
//   clk        : monitor clock
//   rst_n      : asynchronous active-low reset
//   t_in       : toggle signal, asynchronous to clk
//   start      : one-cycle request to open a window (ignored unless idle)
//   window_len : window length in clk cycles, sampled on accepted start
//   busy       : high while a window is open
//   done       : one-cycle pulse when a window closes
//   edge_pulse : one-cycle pulse per synchronised transition, in any state
//   edge_cnt   : transitions counted in the last or current window (saturating)
//   rise_cnt   : 0->1 transitions counted in the last or current window (saturating)
//   overflow   : sticky, set when a counter increment is lost at saturation
module toggle_monitor
    import toggle_monitor_pkg::*;
#(
    parameter int unsigned CNT_W = TM_CNT_W,
    parameter int unsigned WIN_W = TM_WIN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             t_in,
    input  logic             start,
    input  logic [WIN_W-1:0] window_len,
    output logic             busy,
    output logic             done,
    output logic             edge_pulse,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] rise_cnt,
    output logic             overflow
);

    tm_state_e        state_q, state_d;
    logic [WIN_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
    logic             ovf_q, ovf_d;

    logic             sync_level_unused;
    logic             sync_edge;
    logic             sync_rise;

    sync_edge_det u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .d          (t_in),
        .level      (sync_level_unused),
        .edge_pulse (sync_edge),
        .rise       (sync_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= TM_IDLE;
            timer_q    <= '0;
            edge_cnt_q <= '0;
            rise_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            edge_cnt_q <= edge_cnt_d;
            rise_cnt_q <= rise_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        edge_cnt_d = edge_cnt_q;
        rise_cnt_d = rise_cnt_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            TM_IDLE: begin
                if (start) begin
                    edge_cnt_d = '0;
                    rise_cnt_d = '0;
                    ovf_d      = 1'b0;
                    if (window_len != '0) begin
                        timer_d = window_len;
                        state_d = TM_COUNT;
                    end else begin
                        state_d = TM_DONE;
                    end
                end
            end

            TM_COUNT: begin
                // Saturate rather than wrap; a lost increment is remembered in overflow.
                if (sync_edge) begin
                    if (&edge_cnt_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + CNT_W'(1);
                    end
                end
                if (sync_rise) begin
                    if (&rise_cnt_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        rise_cnt_d = rise_cnt_q + CNT_W'(1);
                    end
                end
                timer_d = timer_q - WIN_W'(1);
                // Timer was loaded with window_len, so leaving at 1 gives exactly
                // window_len counting cycles, the last one still counted above.
                if (timer_q == WIN_W'(1)) begin
                    state_d = TM_DONE;
                end
            end

            TM_DONE: begin
                state_d = TM_IDLE;
            end

            default: begin
                state_d = TM_IDLE;
            end
        endcase
    end

    assign busy       = (state_q == TM_COUNT);
    assign done       = (state_q == TM_DONE);
    assign edge_pulse = sync_edge;
    assign edge_cnt   = edge_cnt_q;
    assign rise_cnt   = rise_cnt_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_toggle_monitor.sv
// tb_toggle_monitor
// Two monitors (8-bit and 3-bit counters) share all inputs. A reference model
// keeps the full history of sampled t_in and the accepted window, and derives
// every output from those each cycle; directed scenarios add literal checks.
module tb_toggle_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       t_in = 1'b0;
    logic       start = 1'b0;
    logic [7:0] window_len = 8'd0;

    logic       d8_busy, d8_done, d8_pulse, d8_ovf;
    logic [7:0] d8_edge, d8_rise;
    logic       d3_busy, d3_done, d3_pulse, d3_ovf;
    logic [2:0] d3_edge, d3_rise;

    always #5 clk = ~clk;

    toggle_monitor dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .t_in       (t_in),
        .start      (start),
        .window_len (window_len),
        .busy       (d8_busy),
        .done       (d8_done),
        .edge_pulse (d8_pulse),
        .edge_cnt   (d8_edge),
        .rise_cnt   (d8_rise),
        .overflow   (d8_ovf)
    );

    toggle_monitor #(
        .CNT_W (3),
        .WIN_W (8)
    ) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .t_in       (t_in),
        .start      (start),
        .window_len (window_len),
        .busy       (d3_busy),
        .done       (d3_done),
        .edge_pulse (d3_pulse),
        .edge_cnt   (d3_edge),
        .rise_cnt   (d3_rise),
        .overflow   (d3_ovf)
    );

    // ---------------- reference model ----------------
    localparam int HIST = 16384;
    bit t_at [HIST];
    int cyc = 0;
    int last_rst = 0;
    bit started = 1'b0;
    int s_edge = 0;
    int s_len = 0;

    bit m_busy, m_done, m_pulse, m_ovf8, m_ovf3;
    int m_edge8, m_rise8, m_edge3, m_rise3;

    // Synchronised view of t_in as sampled at edge k; anything at or before the
    // last reset edge has been flushed from the synchroniser.
    function automatic bit eff(input int k);
        if (k <= last_rst || k < 0 || k >= HIST) return 1'b0;
        return t_at[k];
    endfunction

    always @(posedge clk) begin
        int e_raw;
        int r_raw;
        int hi;
        cyc = cyc + 1;
        if (cyc < HIST) t_at[cyc] = t_in;
        if (!rst_n) begin
            last_rst = cyc;
            started = 1'b0;
        end else if (start && (!started || cyc >= s_edge + s_len + 2)) begin
            started = 1'b1;
            s_edge = cyc;
            s_len = int'(window_len);
        end
        // Transition seen by the monitor in the cycle after edge j.
        m_pulse = eff(cyc - 1) ^ eff(cyc - 2);
        e_raw = 0;
        r_raw = 0;
        if (started) begin
            hi = (cyc - 1 < s_edge + s_len - 1) ? cyc - 1 : s_edge + s_len - 1;
            for (int j = s_edge; j <= hi; j++) begin
                if (eff(j - 1) != eff(j - 2)) e_raw++;
                if (eff(j - 1) && !eff(j - 2)) r_raw++;
            end
        end
        m_busy  = started && s_len > 0 && cyc >= s_edge && cyc <= s_edge + s_len - 1;
        m_done  = started && cyc == s_edge + s_len;
        m_edge8 = (e_raw > 255) ? 255 : e_raw;
        m_rise8 = (r_raw > 255) ? 255 : r_raw;
        m_ovf8  = (e_raw > 255) || (r_raw > 255);
        m_edge3 = (e_raw > 7) ? 7 : e_raw;
        m_rise3 = (r_raw > 7) ? 7 : r_raw;
        m_ovf3  = (e_raw > 7) || (r_raw > 7);
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic compare_cycle();
        check("busy8", 64'(d8_busy), 64'(m_busy));
        check("done8", 64'(d8_done), 64'(m_done));
        check("pulse8", 64'(d8_pulse), 64'(m_pulse));
        check("edge_cnt8", 64'(d8_edge), 64'(m_edge8));
        check("rise_cnt8", 64'(d8_rise), 64'(m_rise8));
        check("overflow8", 64'(d8_ovf), 64'(m_ovf8));
        check("busy3", 64'(d3_busy), 64'(m_busy));
        check("done3", 64'(d3_done), 64'(m_done));
        check("pulse3", 64'(d3_pulse), 64'(m_pulse));
        check("edge_cnt3", 64'(d3_edge), 64'(m_edge3));
        check("rise_cnt3", 64'(d3_rise), 64'(m_rise3));
        check("overflow3", 64'(d3_ovf), 64'(m_ovf3));
    endtask

    // ---------------- stimulus ----------------
    int  tog_period = 2;
    bit  tog_rand = 1'b0;

    // Opens a window, optionally re-pulses start in cycle extra_at (1 = first
    // cycle after acceptance), and returns busy-cycle count and done position.
    task automatic run_window(input int len, input int extra_at, output int nbusy,
                              output int ndone);
        @(negedge clk);
        start = 1'b1;
        window_len = 8'(len);
        nbusy = 0;
        ndone = -1;
        for (int i = 1; i <= len + 20; i++) begin
            @(posedge clk);
            #2;
            if (d8_busy) nbusy++;
            if (d8_done && ndone < 0) ndone = i;
            @(negedge clk);
            start = (i == extra_at);
            window_len = 8'($urandom_range(0, 255));
            if (ndone >= 0) break;
        end
        if (start) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic count_dones(input int ncyc, output int ndones);
        ndones = 0;
        repeat (ncyc) begin
            @(posedge clk);
            #2;
            if (d8_done || d3_done) ndones++;
        end
        @(negedge clk);
    endtask

    initial begin
        fork
            // per-cycle model comparison
            forever begin
                @(posedge clk);
                #2;
                compare_cycle();
            end
            // t_in generator: fixed period, or random hold of 2..6 cycles
            begin
                int cnt = 0;
                forever begin
                    @(negedge clk);
                    if (tog_period > 0) begin
                        cnt++;
                        if (cnt >= tog_period) begin
                            t_in = ~t_in;
                            cnt = 0;
                            if (tog_rand) tog_period = $urandom_range(2, 6);
                        end
                    end else begin
                        cnt = 0;
                    end
                end
            end
            // directed and random scenarios
            begin
                int nb, nd, ndn;

                // reset held 3 cycles with t_in toggling
                repeat (3) begin
                    @(posedge clk);
                    #2;
                    check("reset_outputs_zero",
                          64'({d8_busy, d8_done, d8_pulse, d8_edge, d8_rise, d8_ovf}), 64'd0);
                end
                @(negedge clk);
                rst_n = 1'b1;
                count_dones(30, ndn);
                check("idle_no_done", 64'(ndn), 64'd0);
                check("idle_edge_cnt", 64'(d8_edge), 64'd0);

                // nominal window, t_in toggling every 5 cycles
                tog_period = 0;
                t_in = 1'b0;
                repeat (4) @(negedge clk);
                tog_period = 5;
                repeat (20) @(negedge clk);
                run_window(40, 0, nb, nd);
                check("nominal_busy_cycles", 64'(nb), 64'd40);
                check("nominal_done_at", 64'(nd), 64'd41);
                check("nominal_edge_cnt", 64'(d8_edge), 64'd8);
                check("nominal_rise_cnt", 64'(d8_rise), 64'd4);

                // zero-length window
                run_window(0, 0, nb, nd);
                check("zero_busy_cycles", 64'(nb), 64'd0);
                check("zero_done_at", 64'(nd), 64'd1);
                check("zero_edge_cnt", 64'(d8_edge), 64'd0);

                // saturation of the 3-bit instance
                tog_period = 2;
                repeat (10) @(negedge clk);
                run_window(40, 0, nb, nd);
                check("sat_done_at", 64'(nd), 64'd41);
                check("sat_edge_cnt3", 64'(d3_edge), 64'd7);
                check("sat_rise_cnt3", 64'(d3_rise), 64'd7);
                check("sat_overflow3", 64'(d3_ovf), 64'd1);
                check("sat_edge_cnt8", 64'(d8_edge), 64'd20);
                check("sat_rise_cnt8", 64'(d8_rise), 64'd10);
                check("sat_overflow8", 64'(d8_ovf), 64'd0);
                tog_period = 0;
                repeat (6) @(negedge clk);
                run_window(5, 0, nb, nd);
                check("sat_cleared_overflow3", 64'(d3_ovf), 64'd0);
                check("sat_cleared_edge_cnt3", 64'(d3_edge), 64'd0);

                // start mid-window is ignored
                tog_period = 5;
                repeat (20) @(negedge clk);
                run_window(40, 10, nb, nd);
                check("ignored_busy_cycles", 64'(nb), 64'd40);
                check("ignored_done_at", 64'(nd), 64'd41);
                check("ignored_edge_cnt", 64'(d8_edge), 64'd8);
                check("ignored_rise_cnt", 64'(d8_rise), 64'd4);
                count_dones(45, ndn);
                check("ignored_single_done", 64'(ndn), 64'd0);

                // reset 20 cycles into a window
                @(negedge clk);
                start = 1'b1;
                window_len = 8'd40;
                @(negedge clk);
                start = 1'b0;
                repeat (19) @(negedge clk);
                check("midreset_busy_before", 64'(d8_busy), 64'd1);
                rst_n = 1'b0;
                #1;
                check("midreset_busy", 64'(d8_busy), 64'd0);
                check("midreset_counts", 64'({d8_edge, d8_rise, d3_edge}), 64'd0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                count_dones(50, ndn);
                check("midreset_no_done", 64'(ndn), 64'd0);

                // random windows under random t_in hold times
                tog_rand = 1'b1;
                tog_period = 3;
                for (int w = 0; w < 30; w++) begin
                    int len;
                    len = $urandom_range(0, 60);
                    run_window(len, $urandom_range(0, len + 1), nb, nd);
                    check("rand_busy_cycles", 64'(nb), 64'(len));
                    check("rand_done_at", 64'(nd), 64'(len + 1));
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end

                repeat (5) @(negedge clk);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        join
    end

endmodule
